morse_sequencer: RTL

Sequences one Morse character at a time into timed dit/dah drive for the tone_generator.
- Accepts a character as an element pattern (length plus dit/dah bits) over a valid/ready handshake.
- Produces the dit/dah on-times and the element, character and word gaps in units of one Morse "unit".
- Sits between the PS/2-to-Morse lookup and the tone_generator; its dit/dah outputs connect directly to tone_generator dit/dah.

---
 rtl/morse_pkg.sv | 20 ++
 rtl/morse_unit_timer.sv | 28 ++
 rtl/morse_sequencer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/morse_pkg.sv
// Shared state encoding and Morse timing constants (in units) for morse_sequencer.
package morse_pkg;

  localparam int LEN_W = 3;

  localparam logic [2:0] DIT_UNITS        = 3'd1;
  localparam logic [2:0] DAH_UNITS        = 3'd3;
  localparam logic [2:0] ELEM_GAP_UNITS   = 3'd1;
  localparam logic [2:0] CHAR_GAP_UNITS   = 3'd3;
  localparam logic [2:0] WORD_EXTRA_UNITS = 3'd4;

  typedef enum logic [2:0] {
    IDLE,
    ELEM,
    ELEM_GAP,
    CHAR_GAP,
    WORD_GAP
  } state_t;

endpackage

// File: rtl/morse_unit_timer.sv
// Unit prescaler: counts 0..UNIT_CYCLES-1 and flags the terminal count; clear restarts a unit.
module morse_unit_timer #(
  parameter int UNIT_CYCLES = 3000000,
  parameter int CNT_WIDTH   = 22
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic unit_tick
);

  localparam logic [CNT_WIDTH-1:0] TERM = CNT_WIDTH'(UNIT_CYCLES - 1);

  logic [CNT_WIDTH-1:0] cnt;

  assign unit_tick = (cnt == TERM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || unit_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/morse_sequencer.sv
// Sequences one Morse character into registered dit/dah drive and unit-timed gaps.
// Optional `ABORT_EN adds a synchronous abort input that returns the FSM to IDLE.
module morse_sequencer
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 3000000,
  parameter int CNT_WIDTH   = 22,
  parameter int MAX_LEN     = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               code_valid,
  output logic               code_ready,
  input  logic [LEN_W-1:0]   code_len,
  input  logic [MAX_LEN-1:0] code_bits,
  output logic               dit,
  output logic               dah,
  output logic               busy
`ifdef ABORT_EN
  ,
  input  logic               abort
`endif
);

  state_t             state, state_n;
  logic [1:0]         unit_cnt, unit_cnt_n;
  logic [LEN_W-1:0]   rem, rem_n;
  logic [MAX_LEN-1:0] bits_q, bits_n;
  logic               elem_dah, elem_dah_n;
  logic               dit_n, dah_n;
  logic [2:0]         units;
  logic [LEN_W-1:0]   len_c;
  logic               unit_tick, span_done, take, abort_w, timer_clear;

  morse_unit_timer #(
    .UNIT_CYCLES(UNIT_CYCLES),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (timer_clear),
    .unit_tick(unit_tick)
  );

  always_comb begin
    state_n    = state;
    rem_n      = rem;
    bits_n     = bits_q;
    elem_dah_n = elem_dah;
    units      = DIT_UNITS;
`ifdef ABORT_EN
    abort_w    = abort;
`else
    abort_w    = 1'b0;
`endif
    take  = (state == IDLE) && code_valid && !abort_w;
    len_c = (code_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : code_len;

    case (state)
      ELEM:     units = elem_dah ? DAH_UNITS : DIT_UNITS;
      ELEM_GAP: units = ELEM_GAP_UNITS;
      CHAR_GAP: units = CHAR_GAP_UNITS;
      WORD_GAP: units = WORD_EXTRA_UNITS;
      default:  units = DIT_UNITS;
    endcase
    span_done = unit_tick && ({1'b0, unit_cnt} == (units - 3'd1));

    // rem counts elements still to send after the current one; bits_q shifts so bit 0 is current
    case (state)
      IDLE: begin
        if (take) begin
          if (code_len == '0) begin
            state_n = WORD_GAP;
          end else begin
            state_n    = ELEM;
            rem_n      = len_c - 1'b1;
            bits_n     = code_bits;
            elem_dah_n = code_bits[0];
          end
        end
      end
      ELEM: begin
        if (span_done) state_n = (rem == '0) ? CHAR_GAP : ELEM_GAP;
      end
      ELEM_GAP: begin
        if (span_done) begin
          state_n    = ELEM;
          rem_n      = rem - 1'b1;
          bits_n     = bits_q >> 1;
          elem_dah_n = bits_q[1];
        end
      end
      CHAR_GAP, WORD_GAP: begin
        if (span_done) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (abort_w) begin
      state_n = IDLE;
      rem_n   = '0;
    end

    timer_clear = (state_n != state) || (state == IDLE);
    if (timer_clear)    unit_cnt_n = 2'd0;
    else if (unit_tick) unit_cnt_n = unit_cnt + 2'd1;
    else                unit_cnt_n = unit_cnt;

    dit_n = (state_n == ELEM) && !elem_dah_n;
    dah_n = (state_n == ELEM) &&  elem_dah_n;
  end

  // Control and output register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      unit_cnt   <= 2'd0;
      rem        <= '0;
      dit        <= 1'b0;
      dah        <= 1'b0;
      busy       <= 1'b0;
      code_ready <= 1'b1;
    end else begin
      state      <= state_n;
      unit_cnt   <= unit_cnt_n;
      rem        <= rem_n;
      dit        <= dit_n;
      dah        <= dah_n;
      busy       <= (state_n != IDLE);
      code_ready <= (state_n == IDLE);
    end
  end

  always_ff @(posedge clk) begin
    bits_q   <= bits_n;
    elem_dah <= elem_dah_n;
  end

endmodule
